// File: rtl/contador_regressivo.sv
// contador_regressivo: M:SS BCD countdown timer (0:00 .. 9:59) with load/start/stop control.
// Define INTERNAL_TICK_EN to derive the one-second tick from clk via TICKS_PER_SEC instead of tick_in.
module contador_regressivo #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       load,
    input  logic [3:0] load_mins,
    input  logic [3:0] load_sec_tens,
    input  logic [3:0] load_sec_ones,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       zero,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] mins_q, mins_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       done_q, done_d;
    logic       tick;
    logic       count_zero;
    logic       last_sec;

    assign count_zero = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
    assign last_sec   = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);

`ifdef INTERNAL_TICK_EN
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [PW-1:0] presc_q, presc_d;

    assign tick = (state_q == RUNNING) && (presc_q == PW'(TICKS_PER_SEC - 1));

    // Prescaler: restarts on entry to RUNNING, wraps on tick, holds elsewhere.
    always_comb begin
        presc_d = presc_q;
        if (state_d == RUNNING && state_q != RUNNING) begin
            presc_d = '0;
        end else if (state_q == RUNNING) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick = tick_in;
`endif

    // Next state and next count; priority load > stop > start > tick.
    always_comb begin
        state_d = state_q;
        mins_d  = mins_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        if (load && state_q != RUNNING) begin
            mins_d  = (load_mins > 4'd9) ? 4'd9 : load_mins;
            tens_d  = (load_sec_tens > 4'd5) ? 4'd5 : load_sec_tens;
            ones_d  = (load_sec_ones > 4'd9) ? 4'd9 : load_sec_ones;
            state_d = IDLE;
        end else if (stop && state_q == RUNNING) begin
            state_d = PAUSED;
        end else if (stop && state_q == PAUSED) begin
            mins_d  = 4'd0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            state_d = IDLE;
        end else if (start && !count_zero &&
                     (state_q == IDLE || state_q == PAUSED)) begin
            state_d = RUNNING;
        end else if (tick && state_q == RUNNING) begin
            if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else begin
                ones_d = 4'd9;
                if (tens_q != 4'd0) begin
                    tens_d = tens_q - 4'd1;
                end else begin
                    tens_d = 4'd5;
                    mins_d = mins_q - 4'd1;
                end
            end
            if (last_sec) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end
    end

    // State, count and done-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mins_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mins_q  <= mins_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            done_q  <= done_d;
        end
    end

    assign mins     = mins_q;
    assign sec_tens = tens_q;
    assign sec_ones = ones_q;
    assign running  = (state_q == RUNNING);
    assign zero     = count_zero;
    assign done     = done_q;

endmodule

// File: tb/tb_contador_regressivo.sv
// tb_contador_regressivo: directed-vector bench for the BCD countdown timer.
// Expected values are hand-computed constants.
module tb_contador_regressivo;

    logic       clk;
    logic       rst_n;
    logic       tick_in;
    logic       load;
    logic [3:0] load_mins;
    logic [3:0] load_sec_tens;
    logic [3:0] load_sec_ones;
    logic       start;
    logic       stop;
    logic [3:0] mins;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       zero;
    logic       done;

    int n_checks;
    int n_fail;

    contador_regressivo #(.TICKS_PER_SEC(100)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick_in       (tick_in),
        .load          (load),
        .load_mins     (load_mins),
        .load_sec_tens (load_sec_tens),
        .load_sec_ones (load_sec_ones),
        .start         (start),
        .stop          (stop),
        .mins          (mins),
        .sec_tens      (sec_tens),
        .sec_ones      (sec_ones),
        .running       (running),
        .zero          (zero),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt();
        return {20'd0, mins, sec_tens, sec_ones};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] m, input logic [3:0] t,
                           input logic [3:0] o);
        load = 1'b1;
        load_mins = m;
        load_sec_tens = t;
        load_sec_ones = o;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic do_tick();
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        tick_in = 1'b0;
        load = 1'b0;
        load_mins = 4'd0;
        load_sec_tens = 4'd0;
        load_sec_ones = 4'd0;
        start = 1'b0;
        stop = 1'b0;

        #23;
        check("rst_count", cnt(), 32'h000);
        check("rst_running", 32'(running), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        rst_n = 1'b1;
        step();

        // 0:03 countdown to DONE
        do_load(4'd0, 4'd0, 4'd3);
        check("load_003", cnt(), 32'h003);
        check("load_003_zero", 32'(zero), 32'd0);
        do_start();
        check("start_run", 32'(running), 32'd1);
        do_tick();
        check("t1_002", cnt(), 32'h002);
        do_tick();
        check("t2_001", cnt(), 32'h001);
        check("t2_nodone", 32'(done), 32'd0);
        do_tick();
        check("t3_000", cnt(), 32'h000);
        check("t3_done", 32'(done), 32'd1);
        check("t3_running", 32'(running), 32'd0);
        check("t3_zero", 32'(zero), 32'd1);
        step();
        check("done_1cyc", 32'(done), 32'd0);
        do_start();
        check("start_in_done", 32'(running), 32'd0);
        do_tick();
        check("tick_in_done", cnt(), 32'h000);

        // 2:00 borrows through minutes
        do_load(4'd2, 4'd0, 4'd0);
        do_start();
        do_tick();
        check("borrow_159", cnt(), 32'h159);
        for (int i = 0; i < 59; i++) do_tick();
        check("reach_100", cnt(), 32'h100);
        do_tick();
        check("borrow_059", cnt(), 32'h059);
        check("still_run", 32'(running), 32'd1);
        do_stop();
        do_stop();
        check("cancel_000", cnt(), 32'h000);

        // saturation and start on zero
        do_load(4'd12, 4'd7, 4'd15);
        check("sat_959", cnt(), 32'h959);
        do_load(4'd3, 4'd9, 4'd2);
        check("sat_352", cnt(), 32'h352);
        do_load(4'd0, 4'd0, 4'd0);
        do_start();
        check("start_zero", 32'(running), 32'd0);

        // tick outside RUNNING ignored
        do_load(4'd0, 4'd0, 4'd5);
        do_tick();
        check("tick_idle", cnt(), 32'h005);

        // stop beats tick, resume, cancel
        do_load(4'd0, 4'd1, 4'd0);
        do_start();
        stop = 1'b1;
        tick_in = 1'b1;
        step();
        stop = 1'b0;
        tick_in = 1'b0;
        check("stop_tick_cnt", cnt(), 32'h010);
        check("stop_tick_run", 32'(running), 32'd0);
        do_tick();
        check("tick_paused", cnt(), 32'h010);
        do_start();
        check("resume", 32'(running), 32'd1);
        do_tick();
        check("resume_009", cnt(), 32'h009);
        do_stop();
        check("pause_009", cnt(), 32'h009);
        do_stop();
        check("cancel2_000", cnt(), 32'h000);
        check("cancel2_run", 32'(running), 32'd0);
        check("cancel2_zero", 32'(zero), 32'd1);

        // load ignored while running, async reset mid-run
        do_load(4'd5, 4'd0, 4'd0);
        do_start();
        do_tick();
        do_tick();
        check("run_458", cnt(), 32'h458);
        do_load(4'd1, 4'd1, 4'd1);
        check("load_ign_cnt", cnt(), 32'h458);
        check("load_ign_run", 32'(running), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_cnt", cnt(), 32'h000);
        check("async_run", 32'(running), 32'd0);
        check("async_zero", 32'(zero), 32'd1);
        tick_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_nodone", 32'(done), 32'd0);
            check("rst_hold", cnt(), 32'h000);
        end
        tick_in = 1'b0;
        rst_n = 1'b1;
        step();
        check("post_rst_run", 32'(running), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
